// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM states and lane helpers for the LSU memory port.
// LSU_MISALIGN_SPLIT_EN adds the split-access states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT
`ifdef LSU_MISALIGN_SPLIT_EN
        ,
        LD_LO,
        LD_HI,
        ST_HI
`endif
    } lsu_state_t;

    // Lanes over two consecutive words: [3:0] first word, [7:4] spill into the next one.
    function automatic logic [7:0] lane_mask8(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] base;
        case (f3[1:0])
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return {4'b0000, base} << off;
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: picks the addressed bytes out of a two-word window and extends them.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_lo_i,
    input  logic [XLEN-1:0] rdata_hi_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_o
);

    logic [XLEN-1:0] window;

    assign window = XLEN'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});

    always_comb begin
        result_o = '0;
        case (funct3_i)
            F3_B:    result_o = {{(XLEN-8){window[7]}}, window[7:0]};
            F3_H:    result_o = {{(XLEN-16){window[15]}}, window[15:0]};
            F3_W:    result_o = window;
            F3_BU:   result_o = {{(XLEN-8){1'b0}}, window[7:0]};
            F3_HU:   result_o = {{(XLEN-16){1'b0}}, window[15:0]};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store initiator for a synchronous byte-masked data memory.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses instead of raising o_misalign.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 16,
    parameter int XLEN   = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_rsp_valid,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_misalign,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    localparam int WW = MEM_AW - 2;

    lsu_state_t    state_q, state_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    f3_q, f3_d;
    logic [WW-1:0] word_q, word_d;
    logic          illegal_q, illegal_d;
    logic          misalign_q, misalign_d;

    logic [1:0]      reqOff;
    logic [WW-1:0]   reqWord;
    logic [7:0]      reqMask;
    logic            reqLegal;
    logic [XLEN-1:0] alignLo, alignHi, alignOut;
    logic            unused_addr;

    assign reqOff      = i_req_addr[1:0];
    assign reqWord     = i_req_addr[MEM_AW-1:2];
    assign reqMask     = lane_mask8(i_req_funct3, reqOff);
    assign reqLegal    = is_legal(i_req_we, i_req_funct3);
    assign unused_addr = ^i_req_addr[XLEN-1:MEM_AW];
    assign o_misalign  = misalign_q;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [XLEN-1:0] wdata_q, wdata_d, lo_q, lo_d;
    logic [WW-1:0]   wordInc;
    logic [7:0]      ctxMask;

    assign wordInc = word_q + WW'(1);
    assign ctxMask = lane_mask8(f3_q, off_q);
    assign alignLo = (state_q == LD_HI) ? lo_q : i_mem_rdata;
    assign alignHi = (state_q == LD_HI) ? i_mem_rdata : '0;
`else
    assign alignLo = i_mem_rdata;
    assign alignHi = '0;
`endif

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .rdata_lo_i (alignLo),
        .rdata_hi_i (alignHi),
        .off_i      (off_q),
        .funct3_i   (f3_q),
        .result_o   (alignOut)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            off_q      <= '0;
            f3_q       <= '0;
            word_q     <= '0;
            illegal_q  <= 1'b0;
            misalign_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            wdata_q    <= '0;
            lo_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            word_q     <= word_d;
            illegal_q  <= illegal_d;
            misalign_q <= misalign_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            wdata_q    <= wdata_d;
            lo_q       <= lo_d;
`endif
        end
    end

    // Outputs are forced quiet during reset so an aborted access never completes.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        f3_d        = f3_q;
        word_d      = word_q;
        illegal_d   = illegal_q;
        misalign_d  = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        wdata_d     = wdata_q;
        lo_d        = lo_q;
`endif
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_rdata = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        o_mem_wren  = 1'b0;
        if (!i_reset) begin
            case (state_q)
                IDLE: begin
                    o_req_ready = 1'b1;
                    if (i_req_valid) begin
                        off_d     = reqOff;
                        f3_d      = i_req_funct3;
                        word_d    = reqWord;
                        illegal_d = !reqLegal;
                        if (!reqLegal) begin
                            if (!i_req_we) state_d = LD_WAIT;
                        end else if (reqMask[7:4] != 4'b0000) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                            o_mem_addr = {reqWord, 2'b00};
                            if (i_req_we) begin
                                o_mem_wren  = 1'b1;
                                o_mem_bmask = reqMask[3:0];
                                o_mem_wdata = i_req_wdata << {reqOff, 3'b000};
                                wdata_d     = i_req_wdata;
                                state_d     = ST_HI;
                            end else begin
                                state_d = LD_LO;
                            end
`else
                            misalign_d = 1'b1;
`endif
                        end else begin
                            o_mem_addr = {reqWord, 2'b00};
                            if (i_req_we) begin
                                o_mem_wren  = 1'b1;
                                o_mem_bmask = reqMask[3:0];
                                o_mem_wdata = i_req_wdata << {reqOff, 3'b000};
                            end else begin
                                state_d = LD_WAIT;
                            end
                        end
                    end
                end
                LD_WAIT: begin
                    o_mem_addr  = {word_q, 2'b00};
                    o_rsp_valid = 1'b1;
                    o_rsp_rdata = illegal_q ? '0 : alignOut;
                    state_d     = IDLE;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                LD_LO: begin
                    lo_d       = i_mem_rdata;
                    o_mem_addr = {wordInc, 2'b00};
                    state_d    = LD_HI;
                end
                LD_HI: begin
                    o_mem_addr  = {wordInc, 2'b00};
                    o_rsp_valid = 1'b1;
                    o_rsp_rdata = alignOut;
                    state_d     = IDLE;
                end
                ST_HI: begin
                    o_mem_addr  = {wordInc, 2'b00};
                    o_mem_wren  = 1'b1;
                    o_mem_bmask = ctxMask[7:4];
                    o_mem_wdata = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
                    state_d     = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: a byte-array reference model predicts every response,
// a synchronous memory model sits behind the port, and a monitor checks responses as they appear.
module tb_lsu_mem_port;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_misalign;
    logic [15:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;

    typedef struct {
        bit          isMis;
        logic [31:0] data;
        int          due;
    } expT;

    expT         sbQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  refMem [0:65535];
    logic [31:0] memArr [0:16383];
    logic [31:0] memRdata = '0;
    logic [31:0] wword;

    lsu_mem_port #(.MEM_AW(16), .XLEN(32)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_misalign   (o_misalign),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_bmask  (o_mem_bmask),
        .o_mem_wren   (o_mem_wren),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Synchronous byte-masked memory: read data one cycle after the address, zero on write cycles.
    assign i_mem_rdata = memRdata;
    always @(posedge i_clk) begin
        if (o_mem_wren) begin
            wword = memArr[o_mem_addr[15:2]];
            for (int b = 0; b < 4; b++) begin
                if (o_mem_bmask[b]) wword[8*b +: 8] = o_mem_wdata[8*b +: 8];
            end
            memArr[o_mem_addr[15:2]] = wword;
            memRdata <= '0;
        end else begin
            memRdata <= memArr[o_mem_addr[15:2]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    function automatic bit splitEnabled();
`ifdef LSU_MISALIGN_SPLIT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int sizeOf(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legalOf(input logic we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [15:0] a);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < sizeOf(f3); i++) v[8*i +: 8] = refMem[(int'(a) + i) % 65536];
        case (f3)
            3'd0:    v = {{24{v[7]}}, v[7:0]};
            3'd1:    v = {{16{v[15]}}, v[15:0]};
            default: ;
        endcase
        return v;
    endfunction

    // Architectural effect of an accepted request, with C the cycle the request was presented in.
    task automatic modelAccept(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] data, input int c);
        logic [15:0] a;
        int          n;
        bit          legal;
        bit          mis;
        expT         e;
        a     = addr[15:0];
        n     = sizeOf(f3);
        legal = legalOf(we, f3);
        mis   = legal && (int'(a[1:0]) + n > 4);
        if (we) begin
            if (legal && (!mis || splitEnabled())) begin
                for (int i = 0; i < n; i++) refMem[(int'(a) + i) % 65536] = data[8*i +: 8];
            end else if (mis) begin
                e = '{isMis: 1'b1, data: '0, due: c + 1};
                sbQ.push_back(e);
            end
        end else if (!legal) begin
            e = '{isMis: 1'b0, data: '0, due: c + 1};
            sbQ.push_back(e);
        end else if (mis && !splitEnabled()) begin
            e = '{isMis: 1'b1, data: '0, due: c + 1};
            sbQ.push_back(e);
        end else begin
            e = '{isMis: 1'b0, data: refLoad(f3, a), due: c + (mis ? 2 : 1)};
            sbQ.push_back(e);
        end
    endtask

    // Presents a request at posedge+1 and returns at posedge+3 of the cycle it is accepted in.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data, output int waited);
        waited       = 0;
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = data;
        #2;
        while (!o_req_ready && waited < 20) begin
            @(posedge i_clk);
            #3;
            waited++;
        end
        if (!o_req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_accept_timeout actual_ready=0 expected_ready=1");
        end else begin
            modelAccept(we, f3, addr, data, cyc);
        end
    endtask

    task automatic stepCycle();
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic checkQuietOutputs(input string tag);
        checkOutput({tag, "_rsp_valid"}, {31'b0, o_rsp_valid}, 32'd0);
        checkOutput({tag, "_ready"},     {31'b0, o_req_ready}, 32'd1);
        checkOutput({tag, "_wren"},      {31'b0, o_mem_wren},  32'd0);
        checkOutput({tag, "_bmask"},     {28'b0, o_mem_bmask}, 32'd0);
        checkOutput({tag, "_addr"},      {16'b0, o_mem_addr},  32'd0);
        checkOutput({tag, "_wdata"},     o_mem_wdata,          32'd0);
        checkOutput({tag, "_misalign"},  {31'b0, o_misalign},  32'd0);
    endtask

    // Monitor: every response or misalign pulse must match the oldest prediction, on its cycle.
    always @(negedge i_clk) begin
        expT e;
        if (!i_reset && (o_rsp_valid || o_misalign)) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output actual rsp=%0b mis=%0b rdata=0x%08h expected none",
                         o_rsp_valid, o_misalign, o_rsp_rdata);
            end else begin
                e = sbQ.pop_front();
                checkOutput("out_is_misalign", {31'b0, o_misalign}, {31'b0, e.isMis});
                checkOutput("out_is_rsp", {31'b0, o_rsp_valid}, {31'b0, !e.isMis});
                checkOutput("out_cycle", 32'(cyc), 32'(e.due));
                if (!e.isMis) checkOutput("rsp_rdata", o_rsp_rdata, e.data);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          w;
        logic [31:0] r;
        logic [15:0] a;
        for (int i = 0; i < 16384; i++) begin
            r = $urandom();
            memArr[i] = r;
            for (int b = 0; b < 4; b++) refMem[4*i + b] = r[8*b +: 8];
        end
        i_reset      = 1'b1;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'd0;
        i_req_addr   = '0;
        i_req_wdata  = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        #2;
        checkQuietOutputs("reset");
        stepCycle();

        // SW aligned, then SB to the top lane back to back.
        applyStimulus(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, w);
        checkOutput("sw_addr", {16'b0, o_mem_addr}, 32'h0010);
        checkOutput("sw_bmask", {28'b0, o_mem_bmask}, 32'hF);
        checkOutput("sw_wren", {31'b0, o_mem_wren}, 32'd1);
        checkOutput("sw_wdata", o_mem_wdata, 32'hDEAD_BEEF);
        stepCycle();
        applyStimulus(1'b1, 3'd0, 32'h0000_0013, 32'h0000_00A5, w);
        checkOutput("sb_back_to_back_wait", 32'(w), 32'd0);
        checkOutput("sb_addr", {16'b0, o_mem_addr}, 32'h0010);
        checkOutput("sb_bmask", {28'b0, o_mem_bmask}, 32'h8);
        checkOutput("sb_wdata", o_mem_wdata, 32'hA500_0000);
        stepCycle();
        applyStimulus(1'b0, 3'd0, 32'h0000_0013, 32'h0, w);
        checkOutput("lb_wren", {31'b0, o_mem_wren}, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 3'd4, 32'h0000_0013, 32'h0, w);
        stepCycle();

        // Half loads at offset 2, with ready low in the wait cycle.
        applyStimulus(1'b1, 3'd1, 32'h0000_0022, 32'h0000_8001, w);
        stepCycle();
        applyStimulus(1'b0, 3'd1, 32'h0000_0022, 32'h0, w);
        checkOutput("lh_addr", {16'b0, o_mem_addr}, 32'h0020);
        stepCycle();
        #2;
        checkOutput("lh_ready_t1", {31'b0, o_req_ready}, 32'd0);
        stepCycle();
        #2;
        checkOutput("lh_ready_t2", {31'b0, o_req_ready}, 32'd1);
        stepCycle();
        applyStimulus(1'b0, 3'd5, 32'h0000_0022, 32'h0, w);
        stepCycle();

        // Misaligned word load across words 0x0004/0x0008.
        applyStimulus(1'b1, 3'd2, 32'h0000_0004, 32'h4433_2211, w);
        stepCycle();
        applyStimulus(1'b1, 3'd2, 32'h0000_0008, 32'h8877_6655, w);
        stepCycle();
        applyStimulus(1'b0, 3'd2, 32'h0000_0005, 32'h0, w);
        checkOutput("lw_mis_wren", {31'b0, o_mem_wren}, 32'd0);
        checkOutput("lw_mis_bmask", {28'b0, o_mem_bmask}, 32'd0);
        stepCycle();
        repeat (2) stepCycle();

        // Misaligned word store at the top of memory.
        applyStimulus(1'b1, 3'd2, 32'h0000_FFFE, 32'h1122_3344, w);
`ifdef LSU_MISALIGN_SPLIT_EN
        checkOutput("sw_split_lo_addr", {16'b0, o_mem_addr}, 32'hFFFC);
        checkOutput("sw_split_lo_bmask", {28'b0, o_mem_bmask}, 32'hC);
        checkOutput("sw_split_lo_wdata", o_mem_wdata, 32'h3344_0000);
        checkOutput("sw_split_lo_wren", {31'b0, o_mem_wren}, 32'd1);
        stepCycle();
        #2;
        checkOutput("sw_split_hi_addr", {16'b0, o_mem_addr}, 32'h0000);
        checkOutput("sw_split_hi_bmask", {28'b0, o_mem_bmask}, 32'h3);
        checkOutput("sw_split_hi_wdata", o_mem_wdata, 32'h0000_1122);
        checkOutput("sw_split_hi_wren", {31'b0, o_mem_wren}, 32'd1);
        checkOutput("sw_split_hi_ready", {31'b0, o_req_ready}, 32'd0);
`else
        checkOutput("sw_mis_wren", {31'b0, o_mem_wren}, 32'd0);
        checkOutput("sw_mis_bmask", {28'b0, o_mem_bmask}, 32'd0);
`endif
        stepCycle();
        applyStimulus(1'b0, 3'd2, 32'h0000_FFFE, 32'h0, w);
        stepCycle();
        repeat (2) stepCycle();

        // Illegal funct3: load answers zero, store touches nothing.
        applyStimulus(1'b0, 3'd3, 32'h0000_0040, 32'h0, w);
        checkOutput("illegal_ld_wren", {31'b0, o_mem_wren}, 32'd0);
        stepCycle();
        applyStimulus(1'b1, 3'd5, 32'h0000_0040, 32'hFFFF_FFFF, w);
        checkOutput("illegal_st_wren", {31'b0, o_mem_wren}, 32'd0);
        checkOutput("illegal_st_bmask", {28'b0, o_mem_bmask}, 32'd0);
        stepCycle();

        // Reset while a load waits for its data: the response is dropped.
        applyStimulus(1'b0, 3'd2, 32'h0000_0010, 32'h0, w);
        stepCycle();
        i_reset = 1'b1;
        sbQ.delete();
        #2;
        checkOutput("reset_ldwait_rsp", {31'b0, o_rsp_valid}, 32'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        #2;
        checkQuietOutputs("after_reset");
        stepCycle();

        // Random traffic around a small window and around the wrap point.
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            if ($urandom_range(0, 7) == 0) a = 16'hFFF8 + 16'($urandom_range(0, 7));
            else a = 16'h0100 + 16'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {r[31:16], a},
                          $urandom(), w);
            stepCycle();
            repeat ($urandom_range(0, 2)) stepCycle();
        end

        for (int k = 0; k < 20 && sbQ.size() > 0; k++) stepCycle();
        checkOutput("pending_responses", 32'(sbQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
